// File: rtl/push_chk_seq.sv
// Frame tracker and SENDCHECK sequencer between the readout controller and blkcpld.
// Counts words per PUSH frame, then issues a delayed fixed-width check with a one-deep backlog.
module push_chk_seq #(
    parameter int CHK_DLY   = 3,
    parameter int CHK_LEN   = 6,
    parameter int CNT_W     = 8,
    parameter int MIN_WORDS = 1,
    parameter bit XL_SUPP   = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PUSH,
    input  logic             XLOAD,
    input  logic             LASTWORD,
    output logic             SENDCHECK,
    output logic             CHKBUSY,
    output logic [CNT_W-1:0] WORDCNT,
    output logic             CNTVALID,
    output logic             OVFL,
    output logic             DROP,
    output logic             ENDFRM
);

    localparam int TMAX = (CHK_DLY > CHK_LEN) ? CHK_DLY : CHK_LEN;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0]    DLY_T   = TW'(CHK_DLY);
    localparam logic [TW-1:0]    LEN_T   = TW'(CHK_LEN);
    localparam logic [TW-1:0]    ONE_T   = TW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W:0]   MIN_T   = (CNT_W + 1)'(MIN_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_SEND = 2'd2
    } state_t;

    // A zero delay skips WAIT entirely, so back-to-back checks may abut.
    localparam state_t        START_ST = (CHK_DLY == 0) ? S_SEND : S_WAIT;
    localparam logic [TW-1:0] START_TM = (CHK_DLY == 0) ? LEN_T : DLY_T;

    state_t           state, state_n;
    logic [TW-1:0]    timer, timer_n;
    logic             pending, pending_n;
    logic             drop_n, endfrm_n, lw_flag_n;
    logic             push_q, xl_flag, lw_flag, ovf;
    logic [CNT_W-1:0] cnt;

    logic frm_start, frm_end, elig, xl_hit, accept;

    assign frm_start = PUSH & ~push_q;
    assign frm_end   = ~PUSH & push_q;
    assign elig      = PUSH & ~(XLOAD & XL_SUPP);
    assign xl_hit    = PUSH & XLOAD & XL_SUPP;
    assign accept    = frm_end & ~xl_flag & ({1'b0, cnt} >= MIN_T);

    assign SENDCHECK = (state == S_SEND);
    assign CHKBUSY   = (state != S_IDLE) | pending;

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        pending_n = pending;
        drop_n    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = START_ST;
                    timer_n = START_TM;
                end
            end
            S_WAIT: begin
                if (timer == ONE_T) begin
                    state_n = S_SEND;
                    timer_n = LEN_T;
                end else begin
                    timer_n = timer - ONE_T;
                end
                if (accept) begin
                    if (pending) drop_n = 1'b1;
                    else         pending_n = 1'b1;
                end
            end
            S_SEND: begin
                if (timer == ONE_T) begin
                    // The slot frees on this edge, so a frame ending now never drops.
                    if (pending | accept) begin
                        state_n   = START_ST;
                        timer_n   = START_TM;
                        pending_n = pending & accept;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    timer_n = timer - ONE_T;
                    if (accept) begin
                        if (pending) drop_n = 1'b1;
                        else         pending_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        endfrm_n  = lw_flag & (state_n == S_IDLE) & ~pending_n & ~PUSH;
        lw_flag_n = LASTWORD | (lw_flag & ~endfrm_n);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            timer    <= '0;
            pending  <= 1'b0;
            push_q   <= 1'b0;
            cnt      <= '0;
            ovf      <= 1'b0;
            xl_flag  <= 1'b0;
            lw_flag  <= 1'b0;
            WORDCNT  <= '0;
            CNTVALID <= 1'b0;
            OVFL     <= 1'b0;
            DROP     <= 1'b0;
            ENDFRM   <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            pending  <= pending_n;
            push_q   <= PUSH;
            lw_flag  <= lw_flag_n;
            DROP     <= drop_n;
            ENDFRM   <= endfrm_n;
            CNTVALID <= accept;
            if (frm_start) begin
                cnt     <= elig ? CNT_W'(1) : '0;
                ovf     <= 1'b0;
                xl_flag <= xl_hit;
            end else begin
                xl_flag <= xl_flag | xl_hit;
                if (elig) begin
                    if (cnt == CNT_MAX) ovf <= 1'b1;
                    else                cnt <= cnt + CNT_W'(1);
                end
            end
            if (accept) begin
                WORDCNT <= cnt;
                OVFL    <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_push_chk_seq.sv
// Bench for push_chk_seq: four parameter variants, directed frames, tagged expected-event
// queues drained by a negedge monitor.
module tb_push_chk_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] push, xload, lastword;
    logic [3:0] sendcheck, chkbusy, cntvalid, ovfl, drop, endfrm;
    logic [7:0] wc0, wc1, wc2;
    logic [3:0] wc3;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int sc_start [4];
    logic [3:0] sc_prev = '0;

    // Entries are {instance[1:0], payload[29:0]}.
    logic [31:0] exp_cnt_q[$];
    logic [31:0] exp_sc_q[$];
    logic [31:0] exp_drop_q[$];
    logic [31:0] exp_end_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    push_chk_seq u0 (
        .CLK(clk), .RST(rst), .PUSH(push[0]), .XLOAD(xload[0]), .LASTWORD(lastword[0]),
        .SENDCHECK(sendcheck[0]), .CHKBUSY(chkbusy[0]), .WORDCNT(wc0), .CNTVALID(cntvalid[0]),
        .OVFL(ovfl[0]), .DROP(drop[0]), .ENDFRM(endfrm[0])
    );

    push_chk_seq #(.XL_SUPP(1'b0)) u1 (
        .CLK(clk), .RST(rst), .PUSH(push[1]), .XLOAD(xload[1]), .LASTWORD(lastword[1]),
        .SENDCHECK(sendcheck[1]), .CHKBUSY(chkbusy[1]), .WORDCNT(wc1), .CNTVALID(cntvalid[1]),
        .OVFL(ovfl[1]), .DROP(drop[1]), .ENDFRM(endfrm[1])
    );

    push_chk_seq #(.CHK_DLY(10), .CHK_LEN(6)) u2 (
        .CLK(clk), .RST(rst), .PUSH(push[2]), .XLOAD(xload[2]), .LASTWORD(lastword[2]),
        .SENDCHECK(sendcheck[2]), .CHKBUSY(chkbusy[2]), .WORDCNT(wc2), .CNTVALID(cntvalid[2]),
        .OVFL(ovfl[2]), .DROP(drop[2]), .ENDFRM(endfrm[2])
    );

    push_chk_seq #(.CNT_W(4), .CHK_DLY(0), .CHK_LEN(1), .MIN_WORDS(3)) u3 (
        .CLK(clk), .RST(rst), .PUSH(push[3]), .XLOAD(xload[3]), .LASTWORD(lastword[3]),
        .SENDCHECK(sendcheck[3]), .CHKBUSY(chkbusy[3]), .WORDCNT(wc3), .CNTVALID(cntvalid[3]),
        .OVFL(ovfl[3]), .DROP(drop[3]), .ENDFRM(endfrm[3])
    );

    function automatic logic [31:0] tag(input int i, input int v);
        logic [31:0] iv, vv;
        iv = i;
        vv = v;
        return {iv[1:0], vv[29:0]};
    endfunction

    function automatic logic [7:0] get_wc(input int i);
        case (i)
            0:       return wc0;
            1:       return wc1;
            2:       return wc2;
            default: return {4'b0000, wc3};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // which: 0 cntvalid, 1 sendcheck pulse, 2 drop, 3 endfrm
    task automatic chk_pop(input int which, input string name, input logic [31:0] got);
        logic [31:0] exp;
        bit empty;
        case (which)
            0:       empty = (exp_cnt_q.size() == 0);
            1:       empty = (exp_sc_q.size() == 0);
            2:       empty = (exp_drop_q.size() == 0);
            default: empty = (exp_end_q.size() == 0);
        endcase
        n_tests++;
        if (empty) begin
            n_fail++;
            $display("FAIL %s: got %h with nothing expected (cycle %0d)", name, got, cyc);
            return;
        end
        case (which)
            0:       exp = exp_cnt_q.pop_front();
            1:       exp = exp_sc_q.pop_front();
            2:       exp = exp_drop_q.pop_front();
            default: exp = exp_end_q.pop_front();
        endcase
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: outputs settle after posedge, sampled here at negedge.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (cntvalid[i] === 1'b1)
                chk_pop(0, "cntvalid", tag(i, {ovfl[i], get_wc(i)}));
            if (sendcheck[i] === 1'b1 && !sc_prev[i])
                sc_start[i] = cyc;
            if (sendcheck[i] !== 1'b1 && sc_prev[i])
                chk_pop(1, "sendcheck", tag(i, sc_start[i] * 256 + (cyc - sc_start[i])));
            sc_prev[i] = (sendcheck[i] === 1'b1);
            if (drop[i] === 1'b1)
                chk_pop(2, "drop", tag(i, cyc));
            if (endfrm[i] === 1'b1) begin
                chk_pop(3, "endfrm", tag(i, cyc));
                check("endfrm_vs_sendcheck", {31'b0, sendcheck[i]}, 32'd0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives an n-cycle frame; e returns the number of the edge that sees PUSH fall.
    task automatic frame(input int i, input int n, input bit xl, input int lw_at, output int e);
        for (int k = 0; k < n; k++) begin
            push[i]     = 1'b1;
            xload[i]    = xl;
            lastword[i] = (k == lw_at);
            @(negedge clk);
        end
        push[i]     = 1'b0;
        xload[i]    = 1'b0;
        lastword[i] = 1'b0;
        e = cyc + 1;
    endtask

    task automatic exp_cnt(input int i, input int ov, input int w);
        exp_cnt_q.push_back(tag(i, ov * 256 + w));
    endtask

    task automatic exp_sc(input int i, input int start, input int len);
        exp_sc_q.push_back(tag(i, start * 256 + len));
    endtask

    initial begin
        int e, e1;
        rst      = 1'b1;
        push     = '0;
        xload    = '0;
        lastword = '0;
        idle(3);
        check("reset_strobes", {8'b0, sendcheck, chkbusy, cntvalid, ovfl, drop, endfrm}, 32'd0);
        check("reset_wordcnt", {4'b0, wc3, wc2, wc1, wc0}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Single default frame of 96 words.
        frame(0, 96, 1'b0, -1, e);
        exp_cnt(0, 0, 96);
        exp_sc(0, e + 3, 6);
        idle(20);
        check("single_wordcnt", {24'b0, wc0}, 32'd96);

        // Four frames, LASTWORD six cycles after the last fall.
        for (int f = 0; f < 4; f++) begin
            frame(0, 96, 1'b0, -1, e);
            exp_cnt(0, 0, 96);
            exp_sc(0, e + 3, 6);
            if (f < 3) idle(6);
        end
        idle(6);
        lastword[0] = 1'b1;
        exp_end_q.push_back(tag(0, e + 9));
        idle(1);
        lastword[0] = 1'b0;
        idle(20);

        // XLOAD suppression on u0, XLOAD ignored on u1.
        frame(0, 18, 1'b1, -1, e);
        idle(6);
        frame(0, 48, 1'b1, -1, e);
        idle(20);
        check("xl_supp_wordcnt", {24'b0, wc0}, 32'd96);
        check("xl_supp_chkbusy", {31'b0, chkbusy[0]}, 32'd0);

        frame(1, 18, 1'b1, -1, e);
        exp_cnt(1, 0, 18);
        exp_sc(1, e + 3, 6);
        idle(6);
        frame(1, 48, 1'b1, -1, e);
        exp_cnt(1, 0, 48);
        exp_sc(1, e + 3, 6);
        idle(20);
        check("xl_ign_wordcnt", {24'b0, wc1}, 32'd48);

        // Queue overflow: three 2-cycle frames with 1-cycle gaps, long delay.
        frame(2, 2, 1'b0, -1, e1);
        exp_cnt(2, 0, 2);
        exp_sc(2, e1 + 10, 6);
        exp_sc(2, e1 + 26, 6);
        idle(1);
        frame(2, 2, 1'b0, -1, e);
        exp_cnt(2, 0, 2);
        idle(1);
        frame(2, 2, 1'b0, -1, e);
        exp_cnt(2, 0, 2);
        exp_drop_q.push_back(tag(2, e1 + 6));
        idle(40);

        // Saturation, zero delay with width 1, and the MIN_WORDS threshold.
        frame(3, 20, 1'b0, -1, e);
        exp_cnt(3, 1, 15);
        exp_sc(3, e, 1);
        idle(5);
        frame(3, 2, 1'b0, -1, e);
        idle(5);
        check("minwords_wordcnt", {28'b0, wc3}, 32'd15);
        check("minwords_ovfl", {31'b0, ovfl[3]}, 32'd1);
        frame(3, 3, 1'b0, -1, e);
        exp_cnt(3, 0, 3);
        exp_sc(3, e, 1);
        idle(5);
        check("minwords_edge_wordcnt", {28'b0, wc3}, 32'd3);

        // Reset during SEND with a pending frame and LASTWORD already seen.
        frame(0, 10, 1'b0, 4, e);
        exp_cnt(0, 0, 10);
        exp_sc(0, e + 3, 3);
        idle(1);
        frame(0, 2, 1'b0, -1, e1);
        exp_cnt(0, 0, 2);
        idle(3);
        rst = 1'b1;
        idle(1);
        check("rst_sendcheck", {31'b0, sendcheck[0]}, 32'd0);
        check("rst_chkbusy", {31'b0, chkbusy[0]}, 32'd0);
        check("rst_wordcnt", {24'b0, wc0}, 32'd0);
        check("rst_endfrm", {31'b0, endfrm[0]}, 32'd0);
        idle(5);
        rst = 1'b0;
        idle(30);
        check("post_rst_chkbusy", {31'b0, chkbusy[0]}, 32'd0);

        check("drain_cnt", exp_cnt_q.size(), 32'd0);
        check("drain_sc", exp_sc_q.size(), 32'd0);
        check("drain_drop", exp_drop_q.size(), 32'd0);
        check("drain_end", exp_end_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached at cycle %0d, expected finish earlier", cyc);
        $fatal(1, "watchdog");
    end

endmodule
